// File: rtl/fifo_pack_pkg.sv
// Shared types and widths for the FIFO read-side word packer.
package fifo_pack_pkg;

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned KEEP_W         = 4;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned DATA_W         = BYTES_PER_WORD * BYTE_W;
   localparam int unsigned CNT_W          = 3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
   } word_t;

   // Low n lanes enabled; n is the number of captured bytes (0..4).
   function automatic logic [KEEP_W-1:0] keep_mask(input logic [CNT_W-1:0] n);
      logic [KEEP_W:0] one_hot;
      one_hot = (KEEP_W+1)'(1) << n;
      return KEEP_W'(one_hot - (KEEP_W+1)'(1));
   endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by the packer.
interface fifo_word_packer_if;
   import fifo_pack_pkg::*;

   logic              r_empty;
   logic [BYTE_W-1:0] r_data;
   logic              r_en;
   logic [DATA_W-1:0] out_data;
   logic [KEEP_W-1:0] out_keep;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  r_empty, r_data, out_ready,
      output r_en, out_data, out_keep, out_valid
   );

   modport slave (
      output r_empty, r_data, out_ready,
      input  r_en, out_data, out_keep, out_valid
   );

endinterface

// File: rtl/idle_timer.sv
// Saturating idle counter; expired pulses on the increment that reaches TIMEOUT.
module idle_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic r_clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned TIMER_W = 8;

   logic [TIMER_W-1:0] count_q;

   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + TIMER_W'(1);
      end
   end

   assign expired = inc && !clr && ((32'(count_q) + 32'd1) >= TIMEOUT);

endmodule

// File: rtl/fifo_word_packer.sv
// Drains bytes from the FIFO read port into 32-bit little-endian words,
// flushing a partial word with a byte mask after an idle timeout.
module fifo_word_packer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                r_clk,
   input  logic                rst_n,
   fifo_word_packer_if.master  bus
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   word_t             out_q, out_d;
   logic              valid_q, valid_d;
   logic              pend_q;
   logic              run_q;
   logic              rd_req_c;
   logic              idle_inc_c;
   logic              idle_clr_c;
   logic              expired;

   // run_q holds reads off until the first edge after reset release.
   assign rd_req_c = run_q && (state_q == FILL) && !bus.r_empty &&
                     (({1'b0, cnt_q} + {3'b000, pend_q}) < 4'(BYTES_PER_WORD));

   assign idle_inc_c = (state_q == FILL) && (cnt_q != '0) && !pend_q && bus.r_empty;
   assign idle_clr_c = !idle_inc_c;

   idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
      .r_clk   (r_clk),
      .rst_n   (rst_n),
      .clr     (idle_clr_c),
      .inc     (idle_inc_c),
      .expired (expired)
   );

   // Next-state, lane capture and output word load.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      out_d   = out_q;
      valid_d = valid_q;
      unique case (state_q)
         FILL: begin
            if (pend_q) begin
               asm_d[{cnt_q[1:0], 3'b000} +: BYTE_W] = bus.r_data;
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (pend_q && (cnt_q == CNT_W'(BYTES_PER_WORD - 1))) begin
               state_d    = SEND;
               valid_d    = 1'b1;
               out_d.data = asm_d;
               out_d.keep = '1;
            end else if (expired) begin
               state_d    = SEND;
               valid_d    = 1'b1;
               out_d.data = asm_q;
               out_d.keep = keep_mask(cnt_q);
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               state_d = FILL;
               valid_d = 1'b0;
               cnt_d   = '0;
               asm_d   = '0;
               out_d   = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= '0;
         asm_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         pend_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         pend_q  <= rd_req_c;
         run_q   <= 1'b1;
      end
   end

   assign bus.r_en      = rd_req_c;
   assign bus.out_data  = out_q.data;
   assign bus.out_keep  = out_q.keep;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural byte FIFO model.
module tb_fifo_word_packer;

   logic r_clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 r_clk = ~r_clk;

   fifo_word_packer_if bus ();

   fifo_word_packer #(.TIMEOUT(16)) dut (
      .r_clk (r_clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // FIFO model: written by the stimulus, popped by the monitor.
   logic [7:0] mem [0:255];
   int         wp = 0;
   int         rp = 0;
   logic [7:0] rdata_q = 8'h00;
   logic       empty_q = 1'b1;
   logic       ready = 1'b0;
   logic       toggle_en = 1'b0;
   logic       gate = 1'b0;

   assign bus.r_data    = rdata_q;
   assign bus.r_empty   = empty_q;
   assign bus.out_ready = ready;

   always @(negedge r_clk) begin
      if (toggle_en) gate = !gate;
      else           gate = 1'b0;
      empty_q = (wp == rp) || gate;
   end

   int          cyc = 0;
   int          valid_cycles = 0;
   int          viol_empty = 0;
   int          viol_send = 0;
   logic        prev_valid = 1'b0;
   int          ren_cyc_q [$];
   int          vrise_q [$];
   logic [35:0] got_q [$];

   always @(posedge r_clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (bus.r_en) begin
            ren_cyc_q.push_back(cyc);
            if (wp != rp) begin
               rdata_q <= mem[rp % 256];
               rp      <= rp + 1;
            end
            if (bus.r_empty)   viol_empty <= viol_empty + 1;
            if (bus.out_valid) viol_send  <= viol_send + 1;
         end
         if (bus.out_valid) valid_cycles <= valid_cycles + 1;
         if (bus.out_valid && !prev_valid) vrise_q.push_back(cyc);
         if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_keep, bus.out_data});
         prev_valid <= bus.out_valid;
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge r_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp % 256] = b;
      wp = wp + 1;
   endtask

   task automatic wait_words(input int gbase, input int n, input int budget, input string tag);
      int k;
      k = 0;
      while ((got_q.size() - gbase < n) && (k < budget)) begin
         tick(1);
         k++;
      end
      chk(tag, 64'(got_q.size() - gbase), 64'(n));
   endtask

   function automatic logic [35:0] word_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 36'hx_xxxx_xxxx;
   endfunction

   function automatic int ren_at(input int i);
      if (i < ren_cyc_q.size()) return ren_cyc_q[i];
      return -1000;
   endfunction

   function automatic int vrise_at(input int i);
      if (i < vrise_q.size()) return vrise_q[i];
      return 1000000;
   endfunction

   initial begin
      int gbase;
      int rbase;
      int vbase;
      int vc0;
      int k;

      // Reset state
      tick(2);
      chk("rst_r_en",      64'(bus.r_en),      64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_out_keep",  64'(bus.out_keep),  64'd0);
      @(posedge r_clk); #1;
      rst_n = 1'b1;
      tick(3);

      // Full word, ready held high
      ready = 1'b1;
      gbase = got_q.size(); rbase = ren_cyc_q.size(); vbase = vrise_q.size(); vc0 = valid_cycles;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_words(gbase, 1, 30, "full_count");
      tick(3);
      chk("full_word",    64'(word_at(gbase)), 64'h0_F_4433_2211);
      chk("full_ren",     64'(ren_cyc_q.size() - rbase), 64'd4);
      chk("full_latency", 64'(vrise_at(vbase) - ren_at(rbase)), 64'd5);
      chk("full_vcycles", 64'(valid_cycles - vc0), 64'd1);

      // Backpressure with 8 bytes
      ready = 1'b0;
      gbase = got_q.size(); rbase = ren_cyc_q.size();
      for (int i = 1; i <= 8; i++) push(8'(i));
      k = 0;
      while (!bus.out_valid && k < 30) begin tick(1); k++; end
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", 64'({bus.out_keep, bus.out_data}), 64'h0_F_0403_0201);
         tick(1);
      end
      chk("bp_ren_in_send", 64'(ren_cyc_q.size() - rbase), 64'd4);
      ready = 1'b1;
      wait_words(gbase, 2, 40, "bp_count");
      chk("bp_word0", 64'(word_at(gbase)),     64'h0_F_0403_0201);
      chk("bp_word1", 64'(word_at(gbase + 1)), 64'h0_F_0807_0605);
      tick(3);

      // Timeout flush of two bytes
      gbase = got_q.size(); rbase = ren_cyc_q.size(); vbase = vrise_q.size();
      push(8'hAA); push(8'hBB);
      wait_words(gbase, 1, 60, "to_count");
      chk("to_word",    64'(word_at(gbase)), 64'h0_3_0000_BBAA);
      chk("to_latency", 64'(vrise_at(vbase) - ren_at(rbase + 1)), 64'd18);
      tick(3);

      // Empty toggling around 5 bytes
      gbase = got_q.size();
      toggle_en = 1'b1;
      for (int i = 0; i < 5; i++) push(8'(8'h51 + i));
      wait_words(gbase, 2, 120, "tog_count");
      toggle_en = 1'b0;
      chk("tog_word0", 64'(word_at(gbase)),     64'h0_F_5453_5251);
      chk("tog_word1", 64'(word_at(gbase + 1)), 64'h0_1_0000_0055);
      tick(3);

      // Idle for one cycle short of the timeout, then more bytes
      gbase = got_q.size(); rbase = ren_cyc_q.size();
      push(8'hD1); push(8'hD2);
      k = 0;
      while ((ren_cyc_q.size() - rbase < 2) && k < 20) begin tick(1); k++; end
      tick(16);
      push(8'hD3); push(8'hD4);
      wait_words(gbase, 1, 40, "nto_first");
      tick(20);
      chk("nto_count", 64'(got_q.size() - gbase), 64'd1);
      chk("nto_word",  64'(word_at(gbase)), 64'h0_F_D4D3_D2D1);

      // Reset with a partial word held and bytes waiting
      gbase = got_q.size();
      push(8'hE1); push(8'hE2);
      tick(6);
      rst_n = 1'b0;
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      #1;
      chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mrst_out_data",  64'(bus.out_data),  64'd0);
      chk("mrst_out_keep",  64'(bus.out_keep),  64'd0);
      #6;
      chk("mrst_r_empty_low", 64'(bus.r_empty), 64'd0);
      chk("mrst_r_en",        64'(bus.r_en),    64'd0);
      @(posedge r_clk); #1;
      rst_n = 1'b1;
      wait_words(gbase, 1, 40, "mrst_count");
      chk("mrst_word", 64'(word_at(gbase)), 64'h0_F_C4C3_C2C1);
      tick(3);

      chk("ren_while_empty", 64'(viol_empty), 64'd0);
      chk("ren_while_send",  64'(viol_send),  64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
